snap_seq: RTL and testbench



---
 rtl/snap_seq.sv | 116 +++++++++++
 tb/tb_snap_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/snap_seq.sv
// Capture sequencer for a transparent-latch snapshot bank; serialises the snapshot MSB-first.
// Optional trailing parity bit when SNAP_SEQ_PARITY_EN is defined.
module snap_seq #(
    parameter int unsigned W           = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req,
    input  logic [W-1:0] din,
    input  logic         clr,
    input  logic         shift,
    output logic         latch_en,
    output logic         sout,
    output logic         rdy,
    output logic         done,
    output logic         overrun
);

`ifdef SNAP_SEQ_PARITY_EN
    localparam int unsigned NBITS = W + 1;
`else
    localparam int unsigned NBITS = W;
`endif
    localparam int unsigned CW = $clog2(NBITS + 1);

    typedef enum logic [1:0] {IDLE, CAPT, HOLD, FIN} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [SYNC_STAGES:0]   vld_q;
    logic                   req_edge;
    logic [W-1:0]           snap_q;
    logic [CW-1:0]          cnt_q;
`ifdef SNAP_SEQ_PARITY_EN
    logic                   par_q;
`endif

    // vld_q tracks pipeline fill so a req already high at reset release is not seen as an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            prev_q   <= 1'b0;
            vld_q    <= '0;
            req_edge <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], req};
            prev_q   <= sync_q[SYNC_STAGES-1];
            vld_q    <= {vld_q[SYNC_STAGES-1:0], 1'b1};
            req_edge <= sync_q[SYNC_STAGES-1] & ~prev_q & vld_q[SYNC_STAGES];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (req_edge) state_n = CAPT;
            CAPT:    state_n = HOLD;
            HOLD:    if (shift && cnt_q == CW'(1)) state_n = FIN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (clr) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q   <= '0;
            cnt_q    <= '0;
            overrun  <= 1'b0;
            latch_en <= 1'b0;
            rdy      <= 1'b0;
            done     <= 1'b0;
`ifdef SNAP_SEQ_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            latch_en <= (state_n == CAPT);
            rdy      <= (state_n == HOLD);
            done     <= (state_n == FIN);
            if (clr) begin
                overrun <= 1'b0;
            end else begin
                if (req_edge && state != IDLE) overrun <= 1'b1;
                if (state == CAPT) begin
                    snap_q <= din;
                    cnt_q  <= CW'(NBITS);
`ifdef SNAP_SEQ_PARITY_EN
                    par_q  <= ^din;
`endif
                end else if (state == HOLD && shift) begin
                    snap_q <= {snap_q[W-2:0], 1'b0};
                    cnt_q  <= cnt_q - CW'(1);
                end
            end
        end
    end

    always_comb begin
        sout = 1'b0;
        if (state == HOLD) begin
`ifdef SNAP_SEQ_PARITY_EN
            sout = (cnt_q == CW'(1)) ? par_q : snap_q[W-1];
`else
            sout = snap_q[W-1];
`endif
        end
    end

endmodule

// File: tb/tb_snap_seq.sv
// Self-checking bench for snap_seq: table-driven captures, scoreboarded serial stream,
// plus hand-written overrun, clr-abort and reset-mid-transfer sequences.
module tb_snap_seq;

    localparam int unsigned W = 32;
    localparam int unsigned S = 2;
`ifdef SNAP_SEQ_PARITY_EN
    localparam int unsigned NB = W + 1;
`else
    localparam int unsigned NB = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req;
    logic [W-1:0] din;
    logic         clr;
    logic         shift;
    logic         latch_en;
    logic         sout;
    logic         rdy;
    logic         done;
    logic         overrun;

    logic [W-1:0] bank;
    logic         exp_q[$];
    logic         ctr_mode;
    int           checks = 0;
    int           errors = 0;

    snap_seq #(.W(W), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din), .clr(clr), .shift(shift),
        .latch_en(latch_en), .sout(sout), .rdy(rdy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // downstream transparent latch bank
    always_latch begin
        if (latch_en) bank <= din;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ctr_mode) din = din + 1;
    endtask

    task automatic capture(output logic [W-1:0] word);
        int unsigned n;
        req = 1'b0;
        repeat (S + 3) tick();
        req = 1'b1;
        tick();
        n = 1;
        while (!latch_en && n < 20) begin
            tick();
            n++;
        end
        check("capture_latency", 64'(n), 64'(S + 2));
        word = din;
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(word[i]);
`ifdef SNAP_SEQ_PARITY_EN
        exp_q.push_back(^word);
`endif
        tick();
        check("latch_en_one_cycle", 64'(latch_en), 64'(0));
        check("bank_matches", 64'(bank), 64'(word));
        check("rdy_in_hold", 64'(rdy), 64'(1));
    endtask

    task automatic shift_bits(input int unsigned n, input int unsigned gap);
        logic e;
        for (int unsigned i = 0; i < n; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            check("sout_bit", 64'(sout), 64'(e));
            shift = 1'b1;
            tick();
            shift = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic finish_check();
        check("done_pulse", 64'(done), 64'(1));
        check("rdy_falls", 64'(rdy), 64'(0));
        check("sout_idle", 64'(sout), 64'(0));
        tick();
        check("done_one_cycle", 64'(done), 64'(0));
    endtask

    typedef struct {
        logic [W-1:0] din;
        int unsigned  gap;
    } vec_t;

    vec_t         vecs[5];
    logic [W-1:0] word;
    int unsigned  seen;

    initial begin
        vecs[0] = '{32'hA5C3_0F81, 0};
        vecs[1] = '{32'h0000_0007, 0};
        vecs[2] = '{32'hFFFF_FFFF, 1};
        vecs[3] = '{32'h8000_0001, 2};
        vecs[4] = '{32'h0000_0000, 0};

        rst_n = 1'b0; req = 1'b1; din = '0; clr = 1'b0; shift = 1'b0; ctr_mode = 1'b0;
        #1;
        check("reset_latch_en", 64'(latch_en), 64'(0));
        check("reset_rdy", 64'(rdy), 64'(0));
        check("reset_sout", 64'(sout), 64'(0));
        repeat (3) tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            tick();
            if (latch_en) seen++;
        end
        check("req_high_at_release_no_capture", 64'(seen), 64'(0));
        check("req_high_at_release_rdy", 64'(rdy), 64'(0));
        check("req_high_at_release_overrun", 64'(overrun), 64'(0));

        for (int i = 0; i < 5; i++) begin
            din = vecs[i].din;
            capture(word);
            check("captured_word", 64'(word), 64'(vecs[i].din));
            shift_bits(NB - 1, vecs[i].gap);
            check("no_early_done", 64'(done), 64'(0));
            shift_bits(1, 0);
            finish_check();
            seen = 0;
            repeat (8) begin
                tick();
                if (latch_en) seen++;
            end
            check("held_req_single_capture", 64'(seen), 64'(0));
        end

        // free-running din: captured word must be the value present on the latch_en cycle
        ctr_mode = 1'b1;
        din = 32'h1234_0000;
        capture(word);
        shift_bits(NB, 0);
        finish_check();

        // second request during HOLD flags overrun without disturbing the stream
        capture(word);
        shift_bits(5, 0);
        req = 1'b0;
        repeat (5) tick();
        req = 1'b1;
        repeat (6) tick();
        check("overrun_set", 64'(overrun), 64'(1));
        check("overrun_rdy_kept", 64'(rdy), 64'(1));
        shift_bits(NB - 5, 0);
        finish_check();
        check("overrun_sticky", 64'(overrun), 64'(1));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("overrun_cleared", 64'(overrun), 64'(0));
        capture(word);
        shift_bits(NB, 0);
        finish_check();
        check("overrun_after_recapture", 64'(overrun), 64'(0));

        // clr wins over shift in the same cycle
        capture(word);
        shift_bits(10, 0);
        shift = 1'b1;
        clr = 1'b1;
        tick();
        shift = 1'b0;
        clr = 1'b0;
        check("clr_rdy", 64'(rdy), 64'(0));
        check("clr_latch_en", 64'(latch_en), 64'(0));
        check("clr_done", 64'(done), 64'(0));
        check("clr_sout", 64'(sout), 64'(0));
        seen = 0;
        repeat (5) begin
            tick();
            if (done || rdy) seen++;
        end
        check("clr_stays_idle", 64'(seen), 64'(0));
        exp_q.delete();

        // asynchronous reset mid-transfer, req still high afterwards
        capture(word);
        shift_bits(3, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_rdy", 64'(rdy), 64'(0));
        check("async_reset_sout", 64'(sout), 64'(0));
        check("async_reset_overrun", 64'(overrun), 64'(0));
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            tick();
            if (latch_en) seen++;
        end
        check("no_stale_edge_after_reset", 64'(seen), 64'(0));
        capture(word);
        shift_bits(NB, 0);
        finish_check();
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
